ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_pkg.sv | 19 +
 rtl/ram_ctrl_if.sv | 24 ++
 rtl/ram_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared RAM defines: address/data widths, clear default and controller state encodings.
package ram_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] CLR_VALUE_DEF = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_LAST     = 4'hF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WSET = 3'd1,
    WSTB = 3'd2,
    WHLD = 3'd3,
    RSET = 3'd4,
    RCAP = 3'd5
  } state_e;

endpackage

// File: rtl/ram_ctrl_if.sv
// Host-side request/response bundle of the RAM controller.
interface ram_ctrl_if;
  import ram_ctrl_pkg::*;

  logic              req;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              clr;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, req_wr, req_addr, req_wdata, clr,
    input  busy, ack, rdata
  );

  modport slave (
    input  req, req_wr, req_addr, req_wdata, clr,
    output busy, ack, rdata
  );

endinterface

// File: rtl/ram_ctrl.sv
// Sequencer for a 16x8 asynchronous RAM: single writes, single reads and a
// clear-all sweep. Every RAM-side pin and the bus drive-enable are registered.
//
// state | meaning
// IDLE  | waiting; RAM pins quiet, bus released, ack may pulse here
// WSET  | address and data set up on the bus, strobe low
// WSTB  | write strobe high
// WHLD  | strobe low, address/data held; clear mode steps to next address
// RSET  | read enable high, RAM starts driving the bus
// RCAP  | read enable held, bus sampled into rdata on exit
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLR_VALUE = CLR_VALUE_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  ram_ctrl_if.slave         host,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              ram_enable,
  output logic [ADDR_W-1:0] ram_addr
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;      // RAM address, doubles as the clear counter
  logic [DATA_W-1:0] wdata_q;
  logic              clr_mode_q;
  logic              drive_q;
  logic              ram_we_q;
  logic              ram_en_q;
  logic              busy_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;

  // Controller FSM with all outputs registered from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      clr_mode_q <= 1'b0;
      drive_q    <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host.clr) begin
            state_q    <= WSET;
            clr_mode_q <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= CLR_VALUE;
            drive_q    <= 1'b1;
            busy_q     <= 1'b1;
          end else if (host.req && host.req_wr) begin
            state_q    <= WSET;
            clr_mode_q <= 1'b0;
            addr_q     <= host.req_addr;
            wdata_q    <= host.req_wdata;
            drive_q    <= 1'b1;
            busy_q     <= 1'b1;
          end else if (host.req) begin
            state_q    <= RSET;
            clr_mode_q <= 1'b0;
            addr_q     <= host.req_addr;
            ram_en_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        WSET: begin
          state_q  <= WSTB;
          ram_we_q <= 1'b1;
        end
        WSTB: begin
          state_q  <= WHLD;
          ram_we_q <= 1'b0;
        end
        WHLD: begin
          // The sweep stops at the last address rather than wrapping.
          if (clr_mode_q && (addr_q != ADDR_LAST)) begin
            state_q <= WSET;
            addr_q  <= addr_q + 1'b1;
          end else begin
            state_q    <= IDLE;
            clr_mode_q <= 1'b0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b1;
          end
        end
        RSET: begin
          state_q <= RCAP;
        end
        RCAP: begin
          state_q  <= IDLE;
          ram_en_q <= 1'b0;
          busy_q   <= 1'b0;
          ack_q    <= 1'b1;
          rdata_q  <= ram_data;
        end
        default: begin
          state_q    <= IDLE;
          clr_mode_q <= 1'b0;
          drive_q    <= 1'b0;
          ram_we_q   <= 1'b0;
          ram_en_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Bus is only driven during write phases, which never overlap read enable.
  assign ram_data   = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_we     = ram_we_q;
  assign ram_enable = ram_en_q;
  assign ram_addr   = addr_q;

  assign host.busy  = busy_q;
  assign host.ack   = ack_q;
  assign host.rdata = rdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: two controllers (default and all-ones clear value), each
// on a behavioural 16x8 async RAM. Expected acks are queued by the stimulus and
// checked by an independent monitor.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  ram_ctrl_if h0 ();
  ram_ctrl_if h1 ();

  wire  [7:0] ram_data0, ram_data1;
  logic       ram_we0, ram_en0, ram_we1, ram_en1;
  logic [3:0] ram_addr0, ram_addr1;

  ram_ctrl dut0 (
    .clock(clock), .resetn(resetn), .host(h0.slave),
    .ram_data(ram_data0), .ram_we(ram_we0), .ram_enable(ram_en0), .ram_addr(ram_addr0)
  );

  ram_ctrl #(.CLR_VALUE(8'hFF)) dut1 (
    .clock(clock), .resetn(resetn), .host(h1.slave),
    .ram_data(ram_data1), .ram_we(ram_we1), .ram_enable(ram_en1), .ram_addr(ram_addr1)
  );

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  assign ram_data0 = (ram_en0 && !ram_we0) ? mem0[ram_addr0] : 8'hzz;
  assign ram_data1 = (ram_en1 && !ram_we1) ? mem1[ram_addr1] : 8'hzz;

  always @(posedge clock) if (ram_we0 && !ram_en0) mem0[ram_addr0] <= ram_data0;
  always @(posedge clock) if (ram_we1 && !ram_en1) mem1[ram_addr1] <= ram_data1;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle bus rules and scoreboard check of every ack.
  always @(negedge clock) begin
    if (resetn) begin
      chk("we_en_overlap0", {31'd0, ram_we0 & ram_en0}, 32'd0);
      chk("we_en_overlap1", {31'd0, ram_we1 & ram_en1}, 32'd0);
      if (ram_en0 && $isunknown(ram_data0)) chk("bus_x0", 32'd1, 32'd0);
      if (h0.ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          if (e.is_rd) chk("rdata", {24'd0, h0.rdata}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic issue(input logic c, input logic r, input logic wr, input logic [3:0] a,
                       input logic [7:0] d, input bit is_rd, input logic [7:0] exp_d,
                       input int lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (h0.busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (h0.busy) chk("issue_timeout", 32'd1, 32'd0);
    h0.clr = c; h0.req = r; h0.req_wr = wr; h0.req_addr = a; h0.req_wdata = d;
    e.is_rd = is_rd; e.data = exp_d; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clock);
    #1;
    h0.clr = 1'b0; h0.req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || h0.busy) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int n;
    logic [3:0] ff_addrs [3];
    h0.clr = 0; h0.req = 0; h0.req_wr = 0; h0.req_addr = 0; h0.req_wdata = 0;
    h1.clr = 0; h1.req = 0; h1.req_wr = 0; h1.req_addr = 0; h1.req_wdata = 0;
    #2;
    chk("rst_busy",  {31'd0, h0.busy}, 32'd0);
    chk("rst_ack",   {31'd0, h0.ack}, 32'd0);
    chk("rst_rdata", {24'd0, h0.rdata}, 32'd0);
    chk("rst_we",    {31'd0, ram_we0}, 32'd0);
    chk("rst_en",    {31'd0, ram_en0}, 32'd0);
    chk("rst_addr",  {28'd0, ram_addr0}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // write then read back-to-back (second issued in the ack cycle)
    issue(0, 1, 1, 4'd3,  8'hA5, 0, 8'h00, 3);
    issue(0, 1, 0, 4'd3,  8'h00, 1, 8'hA5, 2);
    issue(0, 1, 1, 4'd10, 8'h3C, 0, 8'h00, 3);
    issue(0, 1, 0, 4'd10, 8'h00, 1, 8'h3C, 2);
    issue(0, 1, 1, 4'd15, 8'h81, 0, 8'h00, 3);
    issue(0, 1, 0, 4'd15, 8'h00, 1, 8'h81, 2);
    issue(0, 1, 0, 4'd3,  8'h00, 1, 8'hA5, 2);
    drain();

    // reset asserted while the write strobe is high
    issue(0, 1, 1, 4'd4, 8'h5A, 0, 8'h00, 3);
    @(negedge clock);
    @(negedge clock);
    chk("we_in_wstb", {31'd0, ram_we0}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_we",    {31'd0, ram_we0}, 32'd0);
    chk("abort_busy",  {31'd0, h0.busy}, 32'd0);
    chk("abort_ack",   {31'd0, h0.ack}, 32'd0);
    chk("abort_en",    {31'd0, ram_en0}, 32'd0);
    chk("abort_addr",  {28'd0, ram_addr0}, 32'd0);
    chk("abort_rdata", {24'd0, h0.rdata}, 32'd0);
    chk("abort_bus_released", {31'd0, ram_data0 === 8'h5A}, 32'd0);
    sb.delete();
    @(negedge clock);
    resetn = 1'b1;
    repeat (6) @(negedge clock);
    issue(0, 1, 0, 4'd3, 8'h00, 1, 8'hA5, 2);
    drain();

    // clear with a write request held high for most of the sweep
    issue(1, 0, 0, 4'd0, 8'h00, 0, 8'h00, 48);
    h0.req = 1'b1; h0.req_wr = 1'b1; h0.req_addr = 4'd5; h0.req_wdata = 8'h77;
    n = 0;
    @(negedge clock);
    while (h0.busy && n < 100) begin
      n++;
      if (n == 40) h0.req = 1'b0;
      @(negedge clock);
    end
    h0.req = 1'b0;
    chk("clr_busy_cycles", n, 32'd48);
    issue(0, 1, 0, 4'd0,  8'h00, 1, 8'h00, 2);
    issue(0, 1, 0, 4'd7,  8'h00, 1, 8'h00, 2);
    issue(0, 1, 0, 4'd15, 8'h00, 1, 8'h00, 2);
    issue(0, 1, 0, 4'd5,  8'h00, 1, 8'h00, 2);
    issue(0, 1, 0, 4'd3,  8'h00, 1, 8'h00, 2);
    drain();

    // clr and req together: clear wins
    issue(0, 1, 1, 4'd9, 8'hC3, 0, 8'h00, 3);
    issue(0, 1, 0, 4'd9, 8'h00, 1, 8'hC3, 2);
    issue(1, 1, 1, 4'd9, 8'h66, 0, 8'h00, 48);
    issue(0, 1, 0, 4'd9,  8'h00, 1, 8'h00, 2);
    issue(0, 1, 0, 4'd12, 8'h00, 1, 8'h00, 2);
    drain();

    // all-ones clear value on the second controller
    @(negedge clock);
    h1.clr = 1'b1;
    @(posedge clock);
    #1;
    h1.clr = 1'b0;
    n = 0;
    @(negedge clock);
    while (h1.busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("ff_busy_cycles", n, 32'd48);
    chk("ff_clr_ack", {31'd0, h1.ack}, 32'd1);
    ff_addrs[0] = 4'd0; ff_addrs[1] = 4'd7; ff_addrs[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      h1.req = 1'b1; h1.req_wr = 1'b0; h1.req_addr = ff_addrs[i];
      @(posedge clock);
      #1;
      h1.req = 1'b0;
      repeat (3) @(negedge clock);
      chk("ff_rd_ack", {31'd0, h1.ack}, 32'd1);
      chk("ff_rdata", {24'd0, h1.rdata}, 32'h0000_00FF);
    end

    repeat (4) @(negedge clock);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
